// File: rtl/switch_debouncer_if.sv
// Switch-level bundle between raw mechanical contacts and the debouncer.
// The master side drives the raw levels; the debouncer (slave) returns clean levels and edge strobes.
interface switch_debouncer_if #(
  parameter int N_SW = 2
);
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_clean;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  modport master (output sw_raw, input sw_clean, input sw_rise, input sw_fall);
  modport slave  (input sw_raw, output sw_clean, output sw_rise, output sw_fall);
endinterface

// File: rtl/switch_debouncer.sv
// Per-channel two-flop synchronizer followed by a stability-count FSM; emits a clean level
// and one-cycle rise/fall strobes registered alongside each accepted level change.
module switch_debouncer #(
  parameter int N_SW          = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_debouncer_if.slave  sw
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    SETTLING
  } state_t;

  logic [N_SW-1:0] s1;
  logic [N_SW-1:0] s2;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw.sw_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          clean_q;
    logic          rise_q;
    logic          fall_q;

    // NOTE: every flop here, counter included, is reset so a settle in progress when
    // rst_n drops is discarded rather than resumed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= STABLE;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          STABLE: begin
            if (s2[i] != clean_q) begin
              // A single-sample requirement accepts immediately and never enters SETTLING.
              if (STABLE_CYCLES == 1) begin
                clean_q <= s2[i];
                rise_q  <= s2[i];
                fall_q  <= ~s2[i];
              end else begin
                state <= SETTLING;
                cnt   <= CW'(1);
              end
            end
          end
          SETTLING: begin
            if (s2[i] == clean_q) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              clean_q <= s2[i];
              rise_q  <= s2[i];
              fall_q  <= ~s2[i];
              cnt     <= '0;
              state   <= STABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign sw.sw_clean[i] = clean_q;
    assign sw.sw_rise[i]  = rise_q;
    assign sw.sw_fall[i]  = fall_q;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboarded bench for switch_debouncer: a 4-cycle instance and a 1-cycle instance share
// the raw inputs; expected {clean,rise,fall} per edge are queued by stimulus, popped by monitors.
module tb_switch_debouncer;

  typedef struct {
    string      name;
    logic [5:0] v;
  } exp_t;

  logic clk;
  logic rst_n;

  switch_debouncer_if #(.N_SW(2)) ifa ();
  switch_debouncer_if #(.N_SW(2)) ifb ();

  assign ifb.sw_raw = ifa.sw_raw;

  switch_debouncer #(.N_SW(2), .STABLE_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (ifa)
  );

  switch_debouncer #(.N_SW(2), .STABLE_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got clean/rise/fall=%b_%b_%b want %b_%b_%b", name,
               act[5:4], act[3:2], act[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // Monitors sample on the falling edge, half a period away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check(e.name, {ifa.sw_clean, ifa.sw_rise, ifa.sw_fall}, e.v);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check(e.name, {ifb.sw_clean, ifb.sw_rise, ifb.sw_fall}, e.v);
    end
  end

  // Drive raw before the next rising edge and queue what dut_a must show after it.
  task automatic step(input logic [1:0] raw, input logic [1:0] c, input logic [1:0] r,
                      input logic [1:0] f, input string name);
    exp_t e;
    ifa.sw_raw = raw;
    e.name = name;
    e.v    = {c, r, f};
    qa.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Hold one raw level for n edges; clean moves from 'from' to 'to' at edge chg (0 = never).
  task automatic hold(input string tag, input logic [1:0] raw, input int n,
                      input logic [1:0] from, input logic [1:0] to, input int chg);
    for (int k = 1; k <= n; k++) begin
      step(raw,
           (chg != 0 && k >= chg) ? to : from,
           (k == chg) ? (to & ~from) : 2'b00,
           (k == chg) ? (from & ~to) : 2'b00,
           $sformatf("%s e%0d", tag, k));
    end
  endtask

  initial begin
    exp_t eb;
    rst_n      = 1'b0;
    ifa.sw_raw = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("reset a", {ifa.sw_clean, ifa.sw_rise, ifa.sw_fall}, 6'b0);
    check("reset b", {ifb.sw_clean, ifb.sw_rise, ifb.sw_fall}, 6'b0);
    rst_n = 1'b1;

    hold("power-on 11", 2'b11, 8, 2'b00, 2'b11, 6);
    hold("release 00", 2'b00, 8, 2'b11, 2'b00, 6);
    hold("step ch0", 2'b01, 8, 2'b00, 2'b01, 6);
    hold("clear ch0", 2'b00, 8, 2'b01, 2'b00, 6);

    for (int k = 1; k <= 4; k++)
      step((k % 2 == 1) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, $sformatf("bounce e%0d", k));
    hold("bounce settle", 2'b01, 8, 2'b00, 2'b01, 6);

    for (int k = 1; k <= 3; k++)
      step(2'b00, 2'b01, 2'b00, 2'b00, $sformatf("glitch e%0d", k));
    hold("glitch after", 2'b01, 8, 2'b01, 2'b01, 0);

    hold("pre-both 00", 2'b00, 8, 2'b01, 2'b00, 6);
    hold("both rise", 2'b11, 8, 2'b00, 2'b11, 6);

    // Start a 11->00 settle, then drop rst_n just after edge 4 with no further clock edge.
    for (int k = 1; k <= 3; k++)
      step(2'b00, 2'b11, 2'b00, 2'b00, $sformatf("pre-reset e%0d", k));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset a", {ifa.sw_clean, ifa.sw_rise, ifa.sw_fall}, 6'b0);
    check("async reset b", {ifb.sw_clean, ifb.sw_rise, ifb.sw_fall}, 6'b0);
    ifa.sw_raw = 2'b11;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // After release both instances need their full latency: edge 6 for a, edge 3 for b.
    for (int k = 1; k <= 8; k++) begin
      eb.name = $sformatf("relatch b e%0d", k);
      eb.v    = {(k >= 3) ? 2'b11 : 2'b00, (k == 3) ? 2'b11 : 2'b00, 2'b00};
      qb.push_back(eb);
      step(2'b11, (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00,
           $sformatf("relatch a e%0d", k));
    end

    for (int k = 0; k < 10 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
